multi_clktick: RTL and testbench
================================

Name: multi_clktick

Overview:
- Parametrised multi-channel successor to the single-channel tick divider.
- Each channel emits a one-cycle tick every N+1 enabled cycles (periodic mode) or a single tick after N+1 cycles (one-shot mode).
- Adds per-channel runtime period, pause/resume, synchronous clear and busy status.
- Used by the top level to pace LED sequencers, F1-light delays and the CPU-side timer.

Parameters:
- CHANNELS, 4, number of independent tick channels (>=1).
- WIDTH, 8, counter and period width per channel (>=1).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  CHANNELS  per-channel enable; low pauses the channel.
- mode  input  CHANNELS  per-channel mode: 0 = periodic, 1 = one-shot.
- clr  input  CHANNELS  per-channel synchronous clear.
- N  input  CHANNELS*WIDTH  per-channel period minus one; channel i uses N[i*WIDTH +: WIDTH].
- tick  output  CHANNELS  registered one-cycle tick per channel.
- busy  output  CHANNELS  high while the channel is in RUN.

Behaviour:
- Reset (rst_n=0, asynchronous): every channel goes to IDLE, count=0, tick=0, busy=0. No dependence on N during reset.
- Channels are fully independent; each has a per-channel FSM with states IDLE, RUN and DONE.
- IDLE:
  - en=1 at an edge: count<=N, go to RUN, tick<=0.
  - Otherwise stay in IDLE with tick=0.
- RUN with en=1:
  - count!=0: count<=count-1, tick<=0.
  - count==0: tick<=1 and count<=N, reloading from the current N.
  - On that same tick edge: mode=0 stays in RUN; mode=1 goes to DONE.
- RUN with en=0: count is held (pause), tick<=0. Resuming continues from the held count.
- DONE (one-shot only):
  - tick<=0.
  - en=0 at an edge goes to IDLE. This is the re-arm rule: en must fall, then rise again to retrigger.
  - en=1 stays in DONE.
- busy = (state==RUN), registered with the state.
- Latency:
  - en sampled high at edge k from IDLE gives the first tick high for the cycle after edge k+N+1.
  - Periodic ticks then repeat every N+1 enabled cycles.
  - Each tick is exactly one cycle wide, except N=0 periodic, where tick stays high every enabled cycle.
- N is sampled only at load or reload. Changing N mid-count does not affect the current period.
- mode is sampled only at the tick edge. A mode change mid-count takes effect at the next tick.
- clr=1 at an edge: state to IDLE, count<=0, tick<=0. Clear has priority over en, over the tick and over reload in the same cycle.
- Arithmetic: count is unsigned WIDTH bits. Decrement never wraps because 0 triggers the reload. N = all-ones gives a period of 2^WIDTH.
- rst_n asserted mid-operation: immediate async return to the reset values; no tick is emitted on reset release.

Test Plan:
1. Reset then en[0]=1, mode=0, N0=3 -> tick[0] high for one cycle at cycles 4, 8, 12 after the enable edge; busy[0]=1 throughout.
2. Periodic, N=0 on ch1 -> tick[1] constant 1 from the second enabled edge onward. N=255 on ch2 -> one tick per 256 cycles, no wrap glitch.
3. One-shot ch3 with N=5, en held high -> single tick 6 cycles after enable, then busy=0 and no further ticks. Drop en for one cycle and raise it again -> second tick 6 cycles later.
4. Pause: ch0 N=9, de-assert en for 3 cycles at count=4 -> tick delayed by exactly 3 cycles. Change N to 2 mid-count -> current period still 10, next period 3.
5. clr[0] and count==0 in the same cycle -> no tick, state IDLE, busy=0. Other channels' tick timing is unaffected.
6. Assert rst_n=0 asynchronously between edges while all channels run -> tick and busy go to 0 immediately. On release, no tick until N+1 cycles after the next enable.

Source files
------------

// File: rtl/multi_clktick.sv
// Multi-channel programmable tick divider: each channel emits a one-cycle tick every
// N+1 enabled cycles (periodic) or once after N+1 cycles (one-shot), with pause and clear.
module multi_clktick #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS-1:0]       mode,
   input  logic [CHANNELS-1:0]       clr,
   input  logic [CHANNELS*WIDTH-1:0] N,
   output logic [CHANNELS-1:0]       tick,
   output logic [CHANNELS-1:0]       busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      state_e            state_q, state_d;
      logic [WIDTH-1:0]  count_q, count_d;
      logic              tick_q,  tick_d;
      logic [WIDTH-1:0]  n_ch;

      assign n_ch = N[i*WIDTH +: WIDTH];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            tick_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            count_q <= count_d;
            tick_q  <= tick_d;
         end
      end

      // Clear overrides everything, including a tick/reload due in the same cycle.
      always_comb begin
         state_d = state_q;
         count_d = count_q;
         tick_d  = 1'b0;
         if (clr[i]) begin
            state_d = IDLE;
            count_d = '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (en[i]) begin
                     count_d = n_ch;
                     state_d = RUN;
                  end
               end
               RUN: begin
                  if (en[i]) begin
                     if (count_q == '0) begin
                        tick_d  = 1'b1;
                        count_d = n_ch;
                        if (mode[i]) state_d = DONE;
                     end else begin
                        count_d = count_q - WIDTH'(1);
                     end
                  end
               end
               DONE: begin
                  // en must fall before the one-shot can be retriggered
                  if (!en[i]) state_d = IDLE;
               end
               default: state_d = IDLE;
            endcase
         end
      end

      assign tick[i] = tick_q;
      assign busy[i] = (state_q == RUN);
   end

endmodule

// File: tb/tb_multi_clktick.sv
// Directed bench for multi_clktick: vector tables for periodic/one-shot timing plus
// hand sequences for wide periods, pause, clear priority and asynchronous reset.
module tb_multi_clktick;
   localparam int CH = 4;
   localparam int W  = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CH-1:0] en, mode, clr;
   logic [CH*W-1:0] N;
   logic [CH-1:0] tick, busy;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   multi_clktick #(.CHANNELS(CH), .WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .mode (mode),
      .clr  (clr),
      .N    (N),
      .tick (tick),
      .busy (busy)
   );

   typedef struct {
      logic [3:0] en;
      logic [3:0] mode;
      logic [3:0] clr;
      logic [7:0] n;
      logic [3:0] tick;
      logic [3:0] busy;
   } vec_t;

   vec_t t1[14];
   vec_t t3[19];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      en = '0; mode = '0; clr = '0; N = '0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic apply(input vec_t v, input string nm);
      en   = v.en;
      mode = v.mode;
      clr  = v.clr;
      N    = {4{v.n}};
      cyc();
      chk({nm, " tick"}, 32'(tick), 32'(v.tick));
      chk({nm, " busy"}, 32'(busy), 32'(v.busy));
   endtask

   function automatic logic exp_per(input int e, input int n);
      return (e > 0) && (e % (n + 1) == 0);
   endfunction

   initial begin
      // ch0 periodic N=3: ticks 4, 8, 12 edges after the enable edge
      t1[0]  = '{4'h1, 4'h0, 4'h0, 8'd3, 4'h0, 4'h1};
      t1[1]  = '{4'h1, 4'h0, 4'h0, 8'd3, 4'h0, 4'h1};
      t1[2]  = '{4'h1, 4'h0, 4'h0, 8'd3, 4'h0, 4'h1};
      t1[3]  = '{4'h1, 4'h0, 4'h0, 8'd3, 4'h0, 4'h1};
      t1[4]  = '{4'h1, 4'h0, 4'h0, 8'd3, 4'h1, 4'h1};
      t1[5]  = '{4'h1, 4'h0, 4'h0, 8'd3, 4'h0, 4'h1};
      t1[6]  = '{4'h1, 4'h0, 4'h0, 8'd3, 4'h0, 4'h1};
      t1[7]  = '{4'h1, 4'h0, 4'h0, 8'd3, 4'h0, 4'h1};
      t1[8]  = '{4'h1, 4'h0, 4'h0, 8'd3, 4'h1, 4'h1};
      t1[9]  = '{4'h1, 4'h0, 4'h0, 8'd3, 4'h0, 4'h1};
      t1[10] = '{4'h1, 4'h0, 4'h0, 8'd3, 4'h0, 4'h1};
      t1[11] = '{4'h1, 4'h0, 4'h0, 8'd3, 4'h0, 4'h1};
      t1[12] = '{4'h1, 4'h0, 4'h0, 8'd3, 4'h1, 4'h1};
      t1[13] = '{4'h1, 4'h0, 4'h0, 8'd3, 4'h0, 4'h1};
      // ch3 one-shot N=5: single tick, hold en, drop one cycle, retrigger
      t3[0]  = '{4'h8, 4'h8, 4'h0, 8'd5, 4'h0, 4'h8};
      t3[1]  = '{4'h8, 4'h8, 4'h0, 8'd5, 4'h0, 4'h8};
      t3[2]  = '{4'h8, 4'h8, 4'h0, 8'd5, 4'h0, 4'h8};
      t3[3]  = '{4'h8, 4'h8, 4'h0, 8'd5, 4'h0, 4'h8};
      t3[4]  = '{4'h8, 4'h8, 4'h0, 8'd5, 4'h0, 4'h8};
      t3[5]  = '{4'h8, 4'h8, 4'h0, 8'd5, 4'h0, 4'h8};
      t3[6]  = '{4'h8, 4'h8, 4'h0, 8'd5, 4'h8, 4'h0};
      t3[7]  = '{4'h8, 4'h8, 4'h0, 8'd5, 4'h0, 4'h0};
      t3[8]  = '{4'h8, 4'h8, 4'h0, 8'd5, 4'h0, 4'h0};
      t3[9]  = '{4'h8, 4'h8, 4'h0, 8'd5, 4'h0, 4'h0};
      t3[10] = '{4'h0, 4'h8, 4'h0, 8'd5, 4'h0, 4'h0};
      t3[11] = '{4'h8, 4'h8, 4'h0, 8'd5, 4'h0, 4'h8};
      t3[12] = '{4'h8, 4'h8, 4'h0, 8'd5, 4'h0, 4'h8};
      t3[13] = '{4'h8, 4'h8, 4'h0, 8'd5, 4'h0, 4'h8};
      t3[14] = '{4'h8, 4'h8, 4'h0, 8'd5, 4'h0, 4'h8};
      t3[15] = '{4'h8, 4'h8, 4'h0, 8'd5, 4'h0, 4'h8};
      t3[16] = '{4'h8, 4'h8, 4'h0, 8'd5, 4'h0, 4'h8};
      t3[17] = '{4'h8, 4'h8, 4'h0, 8'd5, 4'h8, 4'h0};
      t3[18] = '{4'h8, 4'h8, 4'h0, 8'd5, 4'h0, 4'h0};

      rst_n = 1'b1;
      do_reset();
      cyc();
      chk("reset tick", 32'(tick), 32'h0);
      chk("reset busy", 32'(busy), 32'h0);

      for (int i = 0; i < 14; i++) apply(t1[i], $sformatf("periodic[%0d]", i));

      do_reset();
      for (int i = 0; i < 19; i++) apply(t3[i], $sformatf("oneshot[%0d]", i));

      // ch1 N=0 always ticking, ch2 N=255 one tick per 256 cycles
      do_reset();
      en = 4'b0110;
      N  = 32'h00FF_0000;
      for (int e = 0; e <= 520; e++) begin
         cyc();
         chk($sformatf("n0 tick1 e%0d", e), 32'(tick[1]), 32'(e >= 1));
         chk($sformatf("n255 tick2 e%0d", e), 32'(tick[2]), 32'(e == 256 || e == 512));
         chk($sformatf("n255 busy2 e%0d", e), 32'(busy[2]), 32'h1);
      end

      // ch0 N=9, pause 3 cycles at count 4, N changed to 2 mid-count
      do_reset();
      for (int e = 0; e < 20; e++) begin
         en = (e >= 6 && e <= 8) ? 4'h0 : 4'h1;
         N  = (e >= 4) ? 32'd2 : 32'd9;
         cyc();
         chk($sformatf("pause tick0 e%0d", e), 32'(tick[0]), 32'(e == 13 || e == 16 || e == 19));
         chk($sformatf("pause busy0 e%0d", e), 32'(busy[0]), 32'h1);
      end

      // clr on ch0 exactly when its tick is due; ch1 keeps its own timing
      do_reset();
      N = 32'h0000_0403;
      for (int e = 0; e < 12; e++) begin
         en  = 4'h3;
         clr = (e == 4) ? 4'h1 : 4'h0;
         cyc();
         chk($sformatf("clr tick0 e%0d", e), 32'(tick[0]), 32'(e == 9));
         chk($sformatf("clr busy0 e%0d", e), 32'(busy[0]), 32'(e != 4));
         chk($sformatf("clr tick1 e%0d", e), 32'(tick[1]), 32'(e == 5 || e == 10));
         chk($sformatf("clr busy1 e%0d", e), 32'(busy[1]), 32'h1);
      end
      clr = 4'h0;

      // asynchronous reset while all channels run
      do_reset();
      N = 32'h0102_0003;
      for (int e = 0; e < 10; e++) begin
         en = 4'hF;
         cyc();
         for (int c = 0; c < 4; c++)
            chk($sformatf("run ch%0d tick e%0d", c, e), 32'(tick[c]), 32'(exp_per(e, int'(N[c*8 +: 8]))));
      end
      #2 rst_n = 1'b0;
      #1;
      chk("async rst tick", 32'(tick), 32'h0);
      chk("async rst busy", 32'(busy), 32'h0);
      en = 4'h0;
      #3 rst_n = 1'b1;
      for (int e = 0; e < 3; e++) begin
         cyc();
         chk($sformatf("post rst tick e%0d", e), 32'(tick), 32'h0);
         chk($sformatf("post rst busy e%0d", e), 32'(busy), 32'h0);
      end
      for (int e = 0; e < 10; e++) begin
         en = 4'hF;
         cyc();
         chk($sformatf("rerun busy e%0d", e), 32'(busy), 32'hF);
         for (int c = 0; c < 4; c++)
            chk($sformatf("rerun ch%0d tick e%0d", c, e), 32'(tick[c]), 32'(exp_per(e, int'(N[c*8 +: 8]))));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
